// File: rtl/ext_pipe_if.sv
// Handshake and data bundle for the ext_pipe immediate generator.
// slave is the generator side, master is the driving/consuming side.
interface ext_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned JIDX_W = 26,
    parameter int unsigned CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  imm;
    logic [JIDX_W-1:0] jidx;
    logic [DATA_W-1:0] pc;
    logic [2:0]        ext_op;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ext_out;
    logic              out_op_err;
    logic [CNT_W-1:0]  err_cnt;

    modport slave (
        input  in_valid, imm, jidx, pc, ext_op, flush, out_ready,
        output in_ready, out_valid, ext_out, out_op_err, err_cnt
    );

    modport master (
        output in_valid, imm, jidx, pc, ext_op, flush, out_ready,
        input  in_ready, out_valid, ext_out, out_op_err, err_cnt
    );
endinterface

// File: rtl/ext_pipe.sv
// Registered immediate generator at the ID/EX boundary: zero/sign/lui/branch/jump forms
// behind a 2-entry skid buffer, with a saturating illegal-op counter.
module ext_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned JIDX_W = 26,
    parameter int unsigned CNT_W  = 8
) (
    input  logic      clk,
    input  logic      reset,
    ext_pipe_if.slave bus
);
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              main_err_q, main_err_d, skid_err_q, skid_err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0] ext_val, sext;
    logic              op_illegal, accept, consume;

    always_comb begin
        sext       = {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
        ext_val    = '0;
        op_illegal = 1'b0;
        case (bus.ext_op)
            3'd0: ext_val = {{(DATA_W-IMM_W){1'b0}}, bus.imm};
            3'd1: ext_val = sext;
            3'd2: ext_val = {bus.imm, {(DATA_W-IMM_W){1'b0}}};
            3'd3: ext_val = sext << 2;
            3'd4: begin
                // Upper PC bits survive; the low field is replaced by the word index.
                ext_val                = bus.pc;
                ext_val[JIDX_W+1:0]    = {bus.jidx, 2'b00};
            end
            default: op_illegal = 1'b1;
        endcase
    end

    assign bus.in_ready   = !reset && (state_q != StFull);
    assign bus.out_valid  = (state_q != StEmpty);
    assign bus.ext_out    = main_q;
    assign bus.out_op_err = main_err_q;
    assign bus.err_cnt    = err_cnt_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign consume = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        main_err_d = main_err_q;
        skid_d     = skid_q;
        skid_err_d = skid_err_q;
        err_cnt_d  = err_cnt_q;

        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d     = ext_val;
                    main_err_d = op_illegal;
                    state_d    = StOne;
                end
            end
            StOne: begin
                if (accept && consume) begin
                    main_d     = ext_val;
                    main_err_d = op_illegal;
                end else if (accept) begin
                    skid_d     = ext_val;
                    skid_err_d = op_illegal;
                    state_d    = StFull;
                end else if (consume) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (consume) begin
                    main_d     = skid_q;
                    main_err_d = skid_err_q;
                    state_d    = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (accept && !bus.flush && op_illegal && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        // Flush beats accept: buffered and incoming entries are dropped, ext_out holds.
        if (bus.flush) begin
            state_d    = StEmpty;
            main_d     = main_q;
            main_err_d = main_err_q;
            skid_d     = skid_q;
            skid_err_d = skid_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            main_err_q <= 1'b0;
            skid_q     <= '0;
            skid_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            main_err_q <= main_err_d;
            skid_q     <= skid_d;
            skid_err_q <= skid_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: vector table, scoreboard on the output handshake,
// and hand-written backpressure / flush / illegal-op / reset sequences.
module tb_ext_pipe;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ext_pipe_if #(.DATA_W(32), .IMM_W(16), .JIDX_W(26), .CNT_W(2)) bus ();

    ext_pipe #(.DATA_W(32), .IMM_W(16), .JIDX_W(26), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] imm;
        logic [25:0] jidx;
        logic [31:0] pc;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } sb_t;

    int  n_vec = 0;
    int  n_bad = 0;
    sb_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic sb_t model(input logic [2:0] op, input logic [15:0] imm,
                                  input logic [25:0] jidx, input logic [31:0] pc);
        sb_t r;
        r.err = 1'b0;
        case (op)
            3'd0: r.data = {16'h0000, imm};
            3'd1: r.data = {{16{imm[15]}}, imm};
            3'd2: r.data = {imm, 16'h0000};
            3'd3: r.data = {{14{imm[15]}}, imm, 2'b00};
            3'd4: r.data = {pc[31:28], jidx, 2'b00};
            default: begin
                r.data = 32'h0;
                r.err  = 1'b1;
            end
        endcase
        return r;
    endfunction

    // Scoreboard: push on accept, pop and compare on consume.
    always @(negedge clk) begin
        sb_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got %h, expected no output", bus.ext_out);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", bus.ext_out, e.data);
                    check("sb_err", {31'h0, bus.out_op_err}, {31'h0, e.err});
                end
            end
            if (bus.flush) sb.delete();
            else if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.ext_op, bus.imm, bus.jidx, bus.pc));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] imm);
        bus.in_valid = 1'b1;
        bus.ext_op   = op;
        bus.imm      = imm;
        bus.jidx     = '0;
        bus.pc       = '0;
    endtask

    vec_t vecs[10];
    logic [1:0] cnt_exp[4];

    initial begin
        vecs[0] = '{3'd0, 16'h8001, 26'h0,       32'h0,        32'h00008001, 1'b0};
        vecs[1] = '{3'd1, 16'h8001, 26'h0,       32'h0,        32'hFFFF8001, 1'b0};
        vecs[2] = '{3'd2, 16'h8001, 26'h0,       32'h0,        32'h80010000, 1'b0};
        vecs[3] = '{3'd3, 16'h8001, 26'h0,       32'h0,        32'hFFFE0004, 1'b0};
        vecs[4] = '{3'd4, 16'h0000, 26'h0000010, 32'hA0000004, 32'hA0000040, 1'b0};
        vecs[5] = '{3'd0, 16'hFFFF, 26'h0,       32'h0,        32'h0000FFFF, 1'b0};
        vecs[6] = '{3'd1, 16'h7FFF, 26'h0,       32'h0,        32'h00007FFF, 1'b0};
        vecs[7] = '{3'd2, 16'h0001, 26'h0,       32'h0,        32'h00010000, 1'b0};
        vecs[8] = '{3'd3, 16'h7FFF, 26'h0,       32'h0,        32'h0001FFFC, 1'b0};
        vecs[9] = '{3'd4, 16'h1234, 26'h3FFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0};
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd3};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.imm       = '0;
        bus.jidx      = '0;
        bus.pc        = '0;
        bus.ext_op    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        step();
        reset = 1'b0;
        #1;
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_ext_out", bus.ext_out, 32'h0);
        check("rst_op_err", {31'h0, bus.out_op_err}, 32'h0);
        check("rst_err_cnt", {30'h0, bus.err_cnt}, 32'h0);
        check("rst_in_ready_low", {31'h0, bus.in_ready}, 32'h1);

        // Back-to-back vector table; each result must be present one edge after accept.
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.ext_op   = vecs[i].op;
            bus.imm      = vecs[i].imm;
            bus.jidx     = vecs[i].jidx;
            bus.pc       = vecs[i].pc;
            step();
            check($sformatf("vec%0d_valid", i), {31'h0, bus.out_valid}, 32'h1);
            check($sformatf("vec%0d_data", i), bus.ext_out, vecs[i].exp);
            check($sformatf("vec%0d_err", i), {31'h0, bus.out_op_err}, {31'h0, vecs[i].exp_err});
        end
        bus.in_valid = 1'b0;
        step();
        check("drain_valid", {31'h0, bus.out_valid}, 32'h0);

        // Backpressure: A then B fill the buffer, then drain in order.
        bus.out_ready = 1'b0;
        drive(3'd1, 16'hFFFF);
        step();
        check("bp_a_in_ready", {31'h0, bus.in_ready}, 32'h1);
        drive(3'd0, 16'h0001);
        step();
        bus.in_valid = 1'b0;
        check("bp_full_in_ready", {31'h0, bus.in_ready}, 32'h0);
        check("bp_hold1", bus.ext_out, 32'hFFFFFFFF);
        step();
        check("bp_hold2", bus.ext_out, 32'hFFFFFFFF);
        check("bp_hold_valid", {31'h0, bus.out_valid}, 32'h1);
        bus.out_ready = 1'b1;
        step();
        check("bp_b_data", bus.ext_out, 32'h00000001);
        check("bp_b_valid", {31'h0, bus.out_valid}, 32'h1);
        check("bp_in_ready_back", {31'h0, bus.in_ready}, 32'h1);
        step();
        check("bp_empty", {31'h0, bus.out_valid}, 32'h0);

        // Flush while FULL with a simultaneous input.
        bus.out_ready = 1'b0;
        drive(3'd0, 16'h1111);
        step();
        drive(3'd0, 16'h2222);
        step();
        drive(3'd0, 16'h3333);
        bus.flush = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("fl_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("fl_ext_hold", bus.ext_out, 32'h00001111);
        bus.out_ready = 1'b1;
        step();
        step();
        check("fl_nothing", {31'h0, bus.out_valid}, 32'h0);

        // Flush in ONE with an acceptable illegal op: it is dropped and not counted.
        bus.out_ready = 1'b0;
        drive(3'd0, 16'h4444);
        step();
        drive(3'd5, 16'h0000);
        bus.flush = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl1_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("fl1_err_cnt", {30'h0, bus.err_cnt}, 32'h0);
        bus.out_ready = 1'b1;
        step();

        // Illegal ops saturate the 2-bit counter.
        for (int i = 0; i < 4; i++) begin
            drive(3'd5, 16'hABCD);
            step();
            check($sformatf("ill%0d_data", i), bus.ext_out, 32'h0);
            check($sformatf("ill%0d_err", i), {31'h0, bus.out_op_err}, 32'h1);
            check($sformatf("ill%0d_cnt", i), {30'h0, bus.err_cnt}, {30'h0, cnt_exp[i]});
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        step();
        bus.flush = 1'b0;
        check("ill_flush_cnt", {30'h0, bus.err_cnt}, 32'h3);

        // Reset while FULL.
        bus.out_ready = 1'b0;
        drive(3'd0, 16'h0005);
        step();
        drive(3'd0, 16'h0006);
        step();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("rf_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rf_err_cnt", {30'h0, bus.err_cnt}, 32'h0);
        check("rf_in_ready", {31'h0, bus.in_ready}, 32'h1);
        bus.out_ready = 1'b1;
        drive(3'd1, 16'h7FFF);
        step();
        bus.in_valid = 1'b0;
        check("rf_next_data", bus.ext_out, 32'h00007FFF);
        step();
        step();
        check("sb_empty", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
Parametrised, registered immediate generator for the MIPS pipeline, placed at the ID/EX boundary. It widens the 16-bit immediate into zero, sign, lui, branch-offset and jump-target forms. Results pass through a 2-entry skid buffer with valid/ready handshake, a flush input, and a saturating error counter for illegal ext_op codes. Output order always equals input order.

Parameters:
DATA_W, 32, output word width; must be >= JIDX_W+2 and >= IMM_W+2
IMM_W, 16, immediate field width
JIDX_W, 26, J-type index field width
CNT_W, 8, width of the saturating illegal-op counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents imm/jidx/pc/ext_op
in_ready  output  1  block can accept this cycle
imm  input  IMM_W  immediate field
jidx  input  JIDX_W  jump index field
pc  input  DATA_W  PC+4 of the instruction (upper bits for jump)
ext_op  input  3  0 zero, 1 sign, 2 lui, 3 branch, 4 jump, 5-7 illegal
flush  input  1  discard all buffered entries
out_valid  output  1  ext_out/out_op_err valid
out_ready  input  1  downstream accepts this cycle
ext_out  output  DATA_W  extended value
out_op_err  output  1  entry came from an illegal ext_op
err_cnt  output  CNT_W  count of accepted illegal ops, saturating

Behaviour:
- Reset is synchronous and active-high; clock and reset ports are named clk and reset.
- Reset values: out_valid=0, ext_out=0, out_op_err=0, err_cnt=0, skid entry empty. in_ready=0 while reset is high.
- Reset mid-operation drops all entries; there is no partial output.
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready.
- in_ready = !reset & !skid_valid (combinational).
- Extension is computed combinationally from the inputs and captured on accept. Latency is 1 cycle: a result accepted on edge N is valid after edge N.
- Op 0: {zeros, imm}.
- Op 1: sign-extend imm[IMM_W-1].
- Op 2: {imm, (DATA_W-IMM_W) zeros}.
- Op 3: sign-extend, then shift left 2; the top bits wrap out, no error.
- Op 4: {pc[DATA_W-1:JIDX_W+2], jidx, 2'b00}.
- Ops 5-7: value 0 and out_op_err=1. err_cnt increments by 1 on accept of an illegal op and holds at all-ones. err_cnt is cleared only by reset; flush does not clear it.
- Buffer states: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
- EMPTY: accept loads main -> ONE.
- ONE, accept and consume: main reloads -> ONE.
- ONE, accept without consume: new entry goes to skid -> FULL, and in_ready drops the next cycle.
- ONE, consume only: -> EMPTY.
- FULL: no accept is possible. Consume moves skid to main -> ONE. ext_out stays stable while out_valid=1 and out_ready=0.
- Flush: the next state is EMPTY and an input presented in the same cycle is dropped (flush beats accept). err_cnt does not count a dropped illegal op. ext_out keeps its old value but out_valid=0.
- Flush and reset together: reset wins (same result plus err_cnt=0).

Test Plan:
- Mode sweep: imm=16'h8001, out_ready=1. Op0 -> 32'h00008001; op1 -> 32'hFFFF8001; op2 -> 32'h80010000; op3 -> 32'hFFFE0004. Each appears exactly 1 cycle after accept.
- Jump: pc=32'hA0000004, jidx=26'h0000010, op4 -> 32'hA0000040, out_op_err=0.
- Backpressure: out_ready=0, send A=op1/16'hFFFF, then B=op0/16'h0001. Required: in_ready=0 after B; ext_out holds 32'hFFFFFFFF. Raise out_ready: outputs A then 32'h00000001 on consecutive cycles; in_ready returns to 1.
- Flush while FULL, with an in_valid input in the same cycle: next cycle out_valid=0, in_ready=1, and the dropped input never emerges.
- Illegal ops, CNT_W=2: send op5 four times -> ext_out=0 and out_op_err=1 each time; err_cnt goes 1,2,3,3. A following flush leaves err_cnt=3.
- Reset asserted for 1 cycle while FULL: next cycle out_valid=0, err_cnt=0, in_ready=1. The next accepted op1/16'h7FFF gives 32'h00007FFF.
